neuron_phase_adapt: RTL and testbench

NEURON_PHASE_ADAPT -- requirements
Module: neuron_phase_adapt

---
 rtl/neuron_phase_adapt.sv | 119 +++++++++++
 tb/tb_neuron_phase_adapt.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_phase_adapt.sv
// Phase-adapting oscillator neuron: a free-running phase counter, neighbour edge
// measurement, mode-driven phase update, stability tracking and a state-change probe.
module neuron_phase_adapt #(
  parameter int PHASE_W     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_N    = 8
) (
  input  logic               sclk,
  input  logic               re,
  input  logic               nin,
  input  logic               full_tick,
  input  logic               drop,
  input  logic               state_cheak,
  input  logic               load_ini,
  input  logic [PHASE_W-1:0] ini_phase,
  input  logic [1:0]         mode,
  output logic               nout,
  output logic [PHASE_W-1:0] phi_out,
  output logic               meas_valid,
  output logic               state_changed,
  output logic               stable
);

  localparam logic [PHASE_W-1:0] ONE      = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] HALF     = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] SYNC_OFF = PHASE_W'(SYNC_STAGES);
  localparam logic [7:0]         STABLE_MAX = 8'(STABLE_N);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_FOLLOW = 2'b01;

  logic [PHASE_W-1:0]     pco_cnt;
  logic [PHASE_W-1:0]     pco_cnt_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise;
  logic [PHASE_W-1:0]     meas;
  logic [PHASE_W-1:0]     step_d;
  logic [PHASE_W-1:0]     phi_next;
  logic                   meas_valid_next;
  logic [7:0]             stable_cnt;
  logic [7:0]             stable_cnt_next;
  logic [PHASE_W-1:0]     snapshot;
  logic [PHASE_W-1:0]     wave;

  assign pco_cnt_next = pco_cnt + ONE;
  assign rise         = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign step_d       = meas - phi_out;

  always_comb begin
    phi_next = phi_out;
    if (load_ini) begin
      phi_next = ini_phase;
    end else if (full_tick && meas_valid) begin
      case (mode)
        MODE_HOLD:   phi_next = phi_out;
        MODE_FOLLOW: phi_next = meas;
        default: begin
          // Half-period tie resolves toward the positive step.
          if (step_d == '0)        phi_next = phi_out;
          else if (step_d <= HALF) phi_next = phi_out + ONE;
          else                     phi_next = phi_out - ONE;
        end
      endcase
    end
  end

  // A fresh edge always survives drop/full_tick; only load_ini discards it.
  always_comb begin
    meas_valid_next = meas_valid;
    if (load_ini)                meas_valid_next = 1'b0;
    else if (rise)               meas_valid_next = 1'b1;
    else if (full_tick || drop)  meas_valid_next = 1'b0;
  end

  always_comb begin
    stable_cnt_next = stable_cnt;
    if (load_ini) begin
      stable_cnt_next = '0;
    end else if (full_tick) begin
      if (phi_next != phi_out)          stable_cnt_next = '0;
      else if (stable_cnt < STABLE_MAX) stable_cnt_next = stable_cnt + 8'd1;
    end
  end

  // Local oscillation is high for the first half-period after the phase point.
  assign wave = pco_cnt_next - phi_next;

  always_ff @(posedge sclk) begin
    if (re) begin
      pco_cnt       <= '0;
      sync_q        <= '0;
      edge_q        <= 1'b0;
      meas          <= '0;
      meas_valid    <= 1'b0;
      phi_out       <= '0;
      stable_cnt    <= '0;
      stable        <= 1'b0;
      snapshot      <= '0;
      state_changed <= 1'b0;
      nout          <= 1'b0;
    end else begin
      pco_cnt    <= pco_cnt_next;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], nin};
      edge_q     <= sync_q[SYNC_STAGES-1];
      if (rise) meas <= pco_cnt - SYNC_OFF;
      meas_valid <= meas_valid_next;
      phi_out    <= phi_next;
      stable_cnt <= stable_cnt_next;
      stable     <= (stable_cnt_next == STABLE_MAX);
      if (state_cheak) begin
        state_changed <= (phi_out != snapshot);
        snapshot      <= phi_out;
      end
      nout <= ~wave[PHASE_W-1];
    end
  end

endmodule

// File: tb/tb_neuron_phase_adapt.sv
// Directed bench for neuron_phase_adapt (PHASE_W=4, SYNC_STAGES=2, STABLE_N=3)
// with a cycle-accurate shadow of the phase counter.
module tb_neuron_phase_adapt;

  logic       sclk = 1'b0;
  logic       re = 1'b1;
  logic       nin = 1'b0;
  logic       full_tick = 1'b0;
  logic       drop = 1'b0;
  logic       state_cheak = 1'b0;
  logic       load_ini = 1'b0;
  logic [3:0] ini_phase = 4'd0;
  logic [1:0] mode = 2'b00;
  logic       nout;
  logic [3:0] phi_out;
  logic       meas_valid;
  logic       state_changed;
  logic       stable;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] pco = 4'd0;

  always #5 sclk = ~sclk;

  neuron_phase_adapt #(
    .PHASE_W(4),
    .SYNC_STAGES(2),
    .STABLE_N(3)
  ) dut (
    .sclk(sclk),
    .re(re),
    .nin(nin),
    .full_tick(full_tick),
    .drop(drop),
    .state_cheak(state_cheak),
    .load_ini(load_ini),
    .ini_phase(ini_phase),
    .mode(mode),
    .nout(nout),
    .phi_out(phi_out),
    .meas_valid(meas_valid),
    .state_changed(state_changed),
    .stable(stable)
  );

  // One clock; the shadow counter tracks the DUT phase counter after the edge.
  task automatic tick();
    @(posedge sclk);
    if (re) pco = 4'd0;
    else    pco = pco + 4'd1;
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic load_phase(input logic [3:0] v);
    ini_phase = v;
    load_ini  = 1'b1;
    tick();
    load_ini  = 1'b0;
  endtask

  task automatic apply_ft(input logic [1:0] m);
    mode      = m;
    full_tick = 1'b1;
    tick();
    full_tick = 1'b0;
  endtask

  // Raise nin while the counter reads m: the edge is detected two cycles later,
  // so the captured measurement is exactly m. Optional drop/full_tick on that edge.
  task automatic capture_at(input logic [3:0] m, input logic with_drop, input logic with_ft);
    repeat (3) tick();
    for (int i = 0; i < 16 && pco != m; i++) tick();
    nin = 1'b1;
    tick();
    tick();
    drop      = with_drop;
    full_tick = with_ft;
    tick();
    drop      = 1'b0;
    full_tick = 1'b0;
    nin       = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_nout", nout, 0);
    check("rst_phi", phi_out, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_state_changed", state_changed, 0);
    check("rst_stable", stable, 0);

    // Free run: nout high for counter 0..7, low for 8..15, first cycle high
    re = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      check("nout_run", nout, (pco < 4'd8) ? 1 : 0);
    end
    check("run_phi", phi_out, 0);

    // load_ini moves the nout rising edge to counter 5
    load_phase(4'd5);
    check("load_phi", phi_out, 5);
    for (int i = 0; i < 17; i++) begin
      tick();
      if (pco == 4'd4) break;
    end
    check("nout_before_rise", nout, 0);
    tick();
    check("nout_at_rise", nout, 1);

    // Follow: edge detected at counter 9 gives meas 7
    capture_at(4'd7, 1'b0, 1'b0);
    check("follow_mv", meas_valid, 1);
    apply_ft(2'b01);
    check("follow_phi", phi_out, 7);
    check("follow_mv_clr", meas_valid, 0);
    apply_ft(2'b01);
    check("ft_no_meas_phi", phi_out, 7);

    // Hold mode consumes the measurement without moving the phase
    capture_at(4'd2, 1'b0, 1'b0);
    apply_ft(2'b00);
    check("hold_phi", phi_out, 7);
    check("hold_mv_clr", meas_valid, 0);

    // Step mode
    load_phase(4'd0);
    capture_at(4'd8, 1'b0, 1'b0);
    apply_ft(2'b10);
    check("step_tie_up", phi_out, 1);
    load_phase(4'd0);
    capture_at(4'd9, 1'b0, 1'b0);
    apply_ft(2'b11);
    check("step_down_wrap", phi_out, 15);
    load_phase(4'd0);
    capture_at(4'd0, 1'b0, 1'b0);
    apply_ft(2'b10);
    check("step_zero", phi_out, 0);
    load_phase(4'd5);
    capture_at(4'd13, 1'b0, 1'b0);
    apply_ft(2'b10);
    check("step_tie_up5", phi_out, 6);

    // drop alone clears; drop with an edge keeps the new capture
    capture_at(4'd3, 1'b0, 1'b0);
    drop = 1'b1;
    tick();
    drop = 1'b0;
    check("drop_mv", meas_valid, 0);
    apply_ft(2'b01);
    check("drop_phi", phi_out, 6);
    capture_at(4'd12, 1'b1, 1'b0);
    check("drop_edge_mv", meas_valid, 1);
    apply_ft(2'b01);
    check("drop_edge_phi", phi_out, 12);

    // full_tick on an edge uses the old meas and keeps the new one pending
    capture_at(4'd3, 1'b0, 1'b0);
    mode = 2'b01;
    capture_at(4'd11, 1'b0, 1'b1);
    check("ft_edge_phi", phi_out, 3);
    check("ft_edge_mv", meas_valid, 1);
    apply_ft(2'b01);
    check("ft_edge_next_phi", phi_out, 11);

    // load_ini beats full_tick
    capture_at(4'd9, 1'b0, 1'b0);
    mode      = 2'b01;
    ini_phase = 4'd6;
    load_ini  = 1'b1;
    full_tick = 1'b1;
    tick();
    load_ini  = 1'b0;
    full_tick = 1'b0;
    check("load_ft_phi", phi_out, 6);
    check("load_ft_mv", meas_valid, 0);
    check("load_stable", stable, 0);

    // Stable after three unchanged updates, cleared by a change
    apply_ft(2'b01);
    apply_ft(2'b01);
    check("stable_two", stable, 0);
    apply_ft(2'b01);
    check("stable_three", stable, 1);
    capture_at(4'd10, 1'b0, 1'b0);
    check("stable_hold", stable, 1);
    apply_ft(2'b01);
    check("change_phi", phi_out, 10);
    check("stable_clr", stable, 0);

    // State-change probe against the snapshot (0 since reset)
    state_cheak = 1'b1;
    tick();
    state_cheak = 1'b0;
    check("state_changed_1", state_changed, 1);
    state_cheak = 1'b1;
    tick();
    state_cheak = 1'b0;
    check("state_changed_2", state_changed, 0);
    tick();
    check("state_changed_hold", state_changed, 0);

    // Mid-operation reset discards the pending measurement
    capture_at(4'd5, 1'b0, 1'b0);
    re = 1'b1;
    tick();
    re = 1'b0;
    check("mid_rst_mv", meas_valid, 0);
    check("mid_rst_phi", phi_out, 0);
    check("mid_rst_nout", nout, 0);
    tick();
    check("post_rst_nout", nout, 1);
    apply_ft(2'b01);
    check("post_rst_phi", phi_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
